cdc_edge_detect_multi: RTL and testbench
========================================

Name: cdc_edge_detect_multi

Overview:
Multi-channel successor to the single-input CDC edge detector.
- Synchronises NUM_CH asynchronous trigger inputs and glitch-filters each channel with a programmable stability length.
- Detects per-channel edges using the EDGE_* encodings from TRIGGER_DELAY_DEFS.vh.
- Combines the masked channel edges into one armed, holdoff-gated trigger pulse that feeds the delay core.

Parameters:
NUM_CH, 4, number of input channels (>=1)
SYNC_STAGES, 3, synchroniser flops per channel (>=2)
FILTER_W, 8, width of filter_len and of each per-channel stability counter
HOLDOFF_W, 16, width of holdoff and of the holdoff counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
async_in  in  NUM_CH  asynchronous trigger inputs
edge_type  in  2*NUM_CH  per-channel edge select, bits [2i+1:2i]: 00 NONE, 01 RISING, 10 FALLING, 11 BOTH
filter_len  in  FILTER_W  extra stable cycles required before a level change is accepted (shared by all channels)
ch_mask  in  NUM_CH  channels that participate in the trigger
combine_mode  in  1  0 = OR (any masked edge fires), 1 = AND (every masked channel has edged since arm)
one_shot  in  1  1 = return to IDLE after a fire
holdoff  in  HOLDOFF_W  dead-time cycles after a fire
arm  in  1  single-cycle arm strobe
disarm  in  1  single-cycle disarm strobe
sync_out  out  NUM_CH  synchronised raw levels (last sync stage)
flt_out  out  NUM_CH  filtered levels
edge_pulse  out  NUM_CH  registered per-channel edge strobes
trig_pulse  out  1  registered combined trigger strobe
trig_ch  out  NUM_CH  masked edge_pulse bits that caused the fire; valid only with trig_pulse, 0 otherwise
armed  out  1  state == ARMED
busy_holdoff  out  1  state == HOLDOFF

Behaviour:
- Reset (rst_n low, async) clears:
  - all sync flops, flt_out, stability counters, edge_pulse, trig_pulse, trig_ch and the seen bits;
  - FSM goes to IDLE, holdoff counter to 0.
- Synchroniser: SYNC_STAGES-flop shift per channel; sync_out is the last stage.
- Filter, per channel, each cycle:
  - if sync == flt: cnt <= 0;
  - else if cnt >= filter_len: flt <= sync, cnt <= 0;
  - else: cnt <= cnt + 1.
  - The new level must persist filter_len+1 consecutive cycles. filter_len = 0 means flt follows sync with 1-cycle delay.
  - A pulse shorter than filter_len+1 cycles never changes flt.
  - The counter does not wrap; cnt stops at filter_len.
- Edge detection:
  - edge_pulse[i] is registered and high for exactly one cycle, coinciding with the cycle flt[i] changes, qualified by edge_type[i].
  - NONE never pulses.
  - Latency from the first clk edge sampling the new async level to edge_pulse high: SYNC_STAGES + filter_len + 1 cycles.
- Trigger FSM, states IDLE / ARMED / HOLDOFF:
  - Priority: disarm > fire > arm.
  - Any state + disarm -> IDLE. trig_pulse is suppressed in that cycle and seen bits are cleared.
  - IDLE + arm -> ARMED, seen cleared. arm while ARMED re-clears seen; arm in HOLDOFF is ignored.
  - ARMED fire condition:
    - OR mode: |(edge_pulse & ch_mask).
    - AND mode: seen_next == ch_mask, where seen_next = seen | (edge_pulse & ch_mask); seen <= seen_next while ARMED.
    - ch_mask == 0 never fires.
  - On fire:
    - trig_pulse = 1 the next cycle (1 cycle after edge_pulse); trig_ch = edge_pulse & ch_mask of the firing cycle; seen cleared.
    - holdoff == 0: next state is IDLE if one_shot, else ARMED.
    - holdoff != 0: next state HOLDOFF, counter <= holdoff.
  - HOLDOFF:
    - counter decrements each cycle;
    - on the cycle counter == 1, exit to IDLE (one_shot) or ARMED;
    - HOLDOFF therefore lasts exactly holdoff cycles;
    - edges during HOLDOFF are ignored and not accumulated.
- Configuration inputs are sampled live each cycle. Changing edge_type, ch_mask or filter_len takes effect on the next clk edge, with no flush.
- edge_pulse and sync_out/flt_out run regardless of FSM state.

Test Plan:
1. Reset/latency: NUM_CH=4, SYNC_STAGES=3, filter_len=0, ch0 RISING, async_in[0] 0->1 → edge_pulse[0] high exactly 4 cycles later for 1 cycle; all outputs 0 during and after reset.
2. Glitch filter: filter_len=5, ch1 BOTH, 5-cycle high pulse → no edge_pulse. 6-cycle pulse → rising edge_pulse[1] 9 cycles after the first edge, then a falling edge_pulse 6 cycles after the synced fall.
3. OR trigger + holdoff: armed, ch_mask=0011, holdoff=10, ch0 edge → trig_pulse 1 cycle later with trig_ch=0001. A ch1 edge 4 cycles later is ignored. busy_holdoff is high 10 cycles, then armed=1.
4. AND mode: ch_mask=0101, ch0 edge then ch2 edge 20 cycles later → single trig_pulse with trig_ch=0100. Disarm between the two edges → no fire; seen cleared.
5. One-shot: one_shot=1, holdoff=0, two ch0 edges → one trig_pulse, armed=0 afterwards. arm → second edge fires.
6. Collisions: disarm asserted in the same cycle as a firing edge_pulse → no trig_pulse, state IDLE. rst_n asserted mid-HOLDOFF → immediate IDLE, busy_holdoff=0.

Source files
------------

// File: rtl/cdc_edge_detect_multi_if.sv
// Configuration, trigger inputs and status outputs of the multi-channel
// CDC edge detector, bundled for the controller (master) and core (slave).
interface cdc_edge_detect_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int FILTER_W  = 8,
    parameter int HOLDOFF_W = 16
);
    logic [NUM_CH-1:0]    async_in;
    logic [2*NUM_CH-1:0]  edge_type;
    logic [FILTER_W-1:0]  filter_len;
    logic [NUM_CH-1:0]    ch_mask;
    logic                 combine_mode;
    logic                 one_shot;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 arm;
    logic                 disarm;
    logic [NUM_CH-1:0]    sync_out;
    logic [NUM_CH-1:0]    flt_out;
    logic [NUM_CH-1:0]    edge_pulse;
    logic                 trig_pulse;
    logic [NUM_CH-1:0]    trig_ch;
    logic                 armed;
    logic                 busy_holdoff;

    modport master (
        output async_in, edge_type, filter_len, ch_mask,
        output combine_mode, one_shot, holdoff, arm, disarm,
        input  sync_out, flt_out, edge_pulse, trig_pulse,
        input  trig_ch, armed, busy_holdoff
    );

    modport slave (
        input  async_in, edge_type, filter_len, ch_mask,
        input  combine_mode, one_shot, holdoff, arm, disarm,
        output sync_out, flt_out, edge_pulse, trig_pulse,
        output trig_ch, armed, busy_holdoff
    );
endinterface

// File: rtl/cdc_edge_detect_multi.sv
// Multi-channel synchroniser, glitch filter and edge detector feeding an
// armed, holdoff-gated combined trigger for the delay core.
module cdc_edge_detect_multi #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_W    = 8,
    parameter int HOLDOFF_W   = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    cdc_edge_detect_multi_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]    sync_d [SYNC_STAGES];
    logic [NUM_CH-1:0]    sync_last;
    logic [NUM_CH-1:0]    flt_q, flt_d;
    logic [FILTER_W-1:0]  cnt_q [NUM_CH];
    logic [FILTER_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0]    edge_q, edge_d;

    state_e               state_q, state_d;
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
    logic [NUM_CH-1:0]    seen_q, seen_d;
    logic                 trig_q, trig_d;
    logic [NUM_CH-1:0]    trig_ch_q, trig_ch_d;

    logic [NUM_CH-1:0]    masked;
    logic [NUM_CH-1:0]    seen_nxt;
    logic                 fire;
    state_e               exit_st;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = bus.async_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Edge strobe is raised on the same cycle the filtered level flips.
    always_comb begin
        flt_d  = flt_q;
        edge_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_last[i] == flt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= bus.filter_len) begin
                flt_d[i]  = sync_last[i];
                cnt_d[i]  = '0;
                edge_d[i] = sync_last[i] ? bus.edge_type[2*i]
                                         : bus.edge_type[2*i+1];
            end else begin
                cnt_d[i] = cnt_q[i] + FILTER_W'(1);
            end
        end
    end

    assign masked   = edge_q & bus.ch_mask;
    assign seen_nxt = seen_q | masked;
    assign exit_st  = bus.one_shot ? IDLE : ARMED;

    always_comb begin
        fire = 1'b0;
        if (state_q == ARMED && |bus.ch_mask) begin
            fire = bus.combine_mode ? (seen_nxt == bus.ch_mask)
                                    : |masked;
        end
    end

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        seen_d    = seen_q;
        trig_d    = 1'b0;
        trig_ch_d = '0;
        if (bus.disarm) begin
            state_d = IDLE;
            hcnt_d  = '0;
            seen_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_d = ARMED;
                        seen_d  = '0;
                    end
                end
                ARMED: begin
                    if (fire) begin
                        trig_d    = 1'b1;
                        trig_ch_d = masked;
                        seen_d    = '0;
                        if (bus.holdoff == '0) begin
                            state_d = exit_st;
                        end else begin
                            state_d = HOLDOFF;
                            hcnt_d  = bus.holdoff;
                        end
                    end else if (bus.arm) begin
                        seen_d = '0;
                    end else begin
                        seen_d = seen_nxt;
                    end
                end
                HOLDOFF: begin
                    hcnt_d = hcnt_q - HOLDOFF_W'(1);
                    if (hcnt_q <= HOLDOFF_W'(1)) begin
                        state_d = exit_st;
                        hcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    seen_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            flt_q     <= '0;
            edge_q    <= '0;
            state_q   <= IDLE;
            hcnt_q    <= '0;
            seen_q    <= '0;
            trig_q    <= 1'b0;
            trig_ch_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            flt_q     <= flt_d;
            edge_q    <= edge_d;
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            seen_q    <= seen_d;
            trig_q    <= trig_d;
            trig_ch_q <= trig_ch_d;
        end
    end

    assign bus.sync_out     = sync_last;
    assign bus.flt_out      = flt_q;
    assign bus.edge_pulse   = edge_q;
    assign bus.trig_pulse   = trig_q;
    assign bus.trig_ch      = trig_ch_q;
    assign bus.armed        = (state_q == ARMED);
    assign bus.busy_holdoff = (state_q == HOLDOFF);

endmodule

// File: tb/tb_cdc_edge_detect_multi.sv
// Directed bench for cdc_edge_detect_multi: latency, glitch filter,
// OR/AND trigger, holdoff, one-shot and disarm/reset collisions.
module tb_cdc_edge_detect_multi;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   tcnt;
    int   tt;
    int   bcnt;
    int   ecnt;
    int   e1;
    int   e2;
    logic [3:0] tch;

    cdc_edge_detect_multi_if #(
        .NUM_CH(4), .FILTER_W(8), .HOLDOFF_W(16)
    ) bus ();

    cdc_edge_detect_multi #(
        .NUM_CH(4), .SYNC_STAGES(3), .FILTER_W(8), .HOLDOFF_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic rec_trig(input int i);
        if (bus.trig_pulse) begin
            tcnt++;
            tt  = i;
            tch = bus.trig_ch;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, bus.sync_out, bus.flt_out, bus.edge_pulse,
                bus.trig_ch, bus.trig_pulse, bus.armed,
                bus.busy_holdoff};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.async_in     = 4'hF;
        bus.edge_type    = '0;
        bus.filter_len   = '0;
        bus.ch_mask      = '0;
        bus.combine_mode = 1'b0;
        bus.one_shot     = 1'b0;
        bus.holdoff      = '0;
        bus.arm          = 1'b0;
        bus.disarm       = 1'b0;

        // reset and base latency
        tick(3);
        check("rst_outs", all_outs(), 0);
        bus.async_in = '0;
        tick(4);
        rst_n = 1'b1;
        tick(2);
        check("post_rst", all_outs(), 0);
        bus.edge_type = 8'h01;
        bus.async_in  = 4'b0001;
        tick(3);
        check("lat_sync", bus.sync_out, 4'b0001);
        check("lat_early", bus.edge_pulse, 0);
        tick();
        check("lat_edge", bus.edge_pulse, 4'b0001);
        check("lat_flt", bus.flt_out, 4'b0001);
        tick();
        check("lat_one", bus.edge_pulse, 0);

        // glitch filter, filter_len = 5
        bus.filter_len  = 8'd5;
        bus.edge_type   = 8'h0D;
        bus.async_in[1] = 1'b1;
        ecnt = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 5) bus.async_in[1] = 1'b0;
            if (bus.edge_pulse[1]) ecnt++;
        end
        check("glitch5", ecnt, 0);
        check("glitch5_flt", bus.flt_out[1], 0);
        bus.async_in[1] = 1'b1;
        ecnt = 0;
        e1   = 0;
        e2   = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 6) bus.async_in[1] = 1'b0;
            if (bus.edge_pulse[1]) begin
                ecnt++;
                if (e1 == 0) e1 = i;
                else e2 = i;
            end
        end
        check("flt6_rise_t", e1, 9);
        check("flt6_fall_t", e2, 15);
        check("flt6_cnt", ecnt, 2);
        bus.filter_len = '0;

        // OR trigger with holdoff = 10
        bus.edge_type = 8'h05;
        bus.ch_mask   = 4'b0011;
        bus.holdoff   = 16'd10;
        bus.async_in[0] = 1'b0;
        tick(6);
        pulse_arm();
        check("or_armed", bus.armed, 1);
        bus.async_in[0] = 1'b1;
        tcnt = 0; tt = 0; tch = '0; bcnt = 0; e1 = 0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 4) bus.async_in[1] = 1'b1;
            rec_trig(i);
            if (bus.busy_holdoff) bcnt++;
            if (bus.edge_pulse[1]) e1 = i;
        end
        check("or_tcnt", tcnt, 1);
        check("or_tt", tt, 5);
        check("or_tch", tch, 4'b0001);
        check("or_busy", bcnt, 10);
        check("or_ch1_t", e1, 8);
        check("or_rearm", bus.armed, 1);

        // AND trigger
        bus.disarm = 1'b1;
        tick();
        bus.disarm       = 1'b0;
        bus.combine_mode = 1'b1;
        bus.ch_mask      = 4'b0101;
        bus.holdoff      = '0;
        bus.edge_type    = 8'h11;
        bus.async_in     = '0;
        tick(6);
        pulse_arm();
        bus.async_in[0] = 1'b1;
        tcnt = 0; tt = 0; tch = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 20) bus.async_in[2] = 1'b1;
            rec_trig(i);
        end
        check("and_tcnt", tcnt, 1);
        check("and_tt", tt, 25);
        check("and_tch", tch, 4'b0100);
        check("and_armed", bus.armed, 1);
        bus.async_in = '0;
        tick(6);
        bus.async_in[0] = 1'b1;
        tcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 12) check("and_idle", bus.armed, 0);
            if (i == 10) bus.disarm = 1'b1;
            if (i == 11) bus.disarm = 1'b0;
            if (i == 12) bus.arm = 1'b1;
            if (i == 13) bus.arm = 1'b0;
            if (i == 20) bus.async_in[2] = 1'b1;
            rec_trig(i);
        end
        check("and_dis_tcnt", tcnt, 0);
        check("and_dis_armed", bus.armed, 1);

        // one-shot
        bus.combine_mode = 1'b0;
        bus.ch_mask      = 4'b0001;
        bus.one_shot     = 1'b1;
        bus.edge_type    = 8'h01;
        bus.async_in     = '0;
        tick(6);
        bus.async_in[0] = 1'b1;
        tcnt = 0; tt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 8) bus.async_in[0] = 1'b0;
            if (i == 14) bus.async_in[0] = 1'b1;
            rec_trig(i);
        end
        check("os_tcnt", tcnt, 1);
        check("os_tt", tt, 5);
        check("os_armed", bus.armed, 0);
        pulse_arm();
        bus.async_in[0] = 1'b0;
        tick(6);
        bus.async_in[0] = 1'b1;
        tcnt = 0; tt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            rec_trig(i);
        end
        check("os2_tcnt", tcnt, 1);
        check("os2_tt", tt, 5);

        // disarm colliding with a firing edge
        bus.one_shot = 1'b0;
        pulse_arm();
        bus.async_in[0] = 1'b0;
        tick(6);
        bus.async_in[0] = 1'b1;
        tcnt = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 4) begin
                check("col_edge", bus.edge_pulse, 4'b0001);
                bus.disarm = 1'b1;
            end
            if (i == 5) bus.disarm = 1'b0;
            rec_trig(i);
        end
        check("col_tcnt", tcnt, 0);
        check("col_armed", bus.armed, 0);
        check("col_busy", bus.busy_holdoff, 0);

        // reset in the middle of holdoff
        bus.holdoff = 16'd50;
        pulse_arm();
        bus.async_in[0] = 1'b0;
        tick(6);
        bus.async_in[0] = 1'b1;
        tick(8);
        check("rh_busy", bus.busy_holdoff, 1);
        rst_n = 1'b0;
        #1;
        check("rh_busy0", bus.busy_holdoff, 0);
        check("rh_armed0", bus.armed, 0);
        check("rh_flt0", bus.flt_out, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rh_idle", {bus.armed, bus.busy_holdoff}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
